// File: rtl/fifo_rr_push_arbiter_pkg.sv
// rtl/fifo_rr_push_arbiter_pkg.sv - shared defaults, entry type and index helper for the push arbiter
package fifo_rr_push_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF      = 8;
    localparam int unsigned QUOTA_DEF      = 4;
    localparam int unsigned ID_W_DEF       = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic [ID_W_DEF-1:0]       id;
        logic [DATA_WIDTH_DEF-1:0] data;
    } entry_t;

    // Modulo-n increment that works for non-power-of-two ranges.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cva6_fifo_v3.sv
// rtl/cva6_fifo_v3.sv - entry storage FIFO with synchronous clear and non-power-of-two wrap
module cva6_fifo_v3
    import fifo_rr_push_arbiter_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter bit          FPGA_EN      = 1'b0,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    logic                  do_write;
    logic                  unused_testmode;
    dtype                  mem_q [DEPTH];

    assign unused_testmode = testmode_i;

    assign full_o   = (status_cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o  = (status_cnt_q == '0) & ~(FALL_THROUGH & push_i);
    // Deliberately truncated when the FIFO holds exactly DEPTH entries.
    assign usage_o  = status_cnt_q[ADDR_DEPTH-1:0];
    assign do_write = push_i & ~full_o;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        status_cnt_d = status_cnt_q;
        data_o       = mem_q[rd_ptr_q];
        if (do_write) begin
            wr_ptr_d     = ADDR_DEPTH'(wrap_inc(32'(wr_ptr_q), DEPTH));
            status_cnt_d = status_cnt_d + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d     = ADDR_DEPTH'(wrap_inc(32'(rd_ptr_q), DEPTH));
            status_cnt_d = status_cnt_d - 1'b1;
        end
        if (FALL_THROUGH && (status_cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                rd_ptr_d     = rd_ptr_q;
                wr_ptr_d     = wr_ptr_q;
                status_cnt_d = status_cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            status_cnt_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            status_cnt_q <= status_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// rtl/fifo_rr_push_arbiter.sv - round-robin, quota-limited push arbiter in front of a shared tagged FIFO
module fifo_rr_push_arbiter
    import fifo_rr_push_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned QUOTA      = QUOTA_DEF,
    parameter int unsigned ID_W       = $clog2(NUM_REQ),
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic                                out_valid_o,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic [ID_W-1:0]                     out_id_o,
    input  logic                                out_ready_i,
    output logic [NUM_REQ-1:0][CNT_W-1:0]       occupancy_o,
    output logic [CNT_W-1:0]                    usage_o
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Same layout as the package entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
    } arb_entry_t;

    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]              total_q, total_d;
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]            elig;
    logic [ID_W-1:0]               winner;
    logic                          grant_valid;
    logic                          full;
    logic                          push;
    logic                          pop;
    logic                          clear;
    arb_entry_t                    push_entry;
    arb_entry_t                    head_entry;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [ADDR_W-1:0]             fifo_usage;

    assign clear = flush_i | ~rst_ni;
    assign full  = (total_q == CNT_W'(DEPTH));

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid_i[i] & (cnt_q[i] < CNT_W'(QUOTA)) & ~full & ~flush_i & rst_ni;
        end
    end

    // Scan starts at rr_ptr and wraps; first eligible requester wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        winner      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && elig[idx[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                winner      = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_valid) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign push             = |req_ready_o;
    assign out_valid_o      = (total_q != '0) & ~flush_i & rst_ni;
    assign pop              = out_valid_o & out_ready_i;
    assign push_entry.id    = winner;
    assign push_entry.data  = req_data_i[winner];

    always_comb begin
        cnt_d    = cnt_q;
        total_d  = total_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            cnt_d[winner] = cnt_d[winner] + 1'b1;
            total_d       = total_d + 1'b1;
            rr_ptr_d      = ID_W'(wrap_inc(32'(winner), NUM_REQ));
        end
        if (pop) begin
            cnt_d[head_entry.id] = cnt_d[head_entry.id] - 1'b1;
            total_d              = total_d - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            cnt_q    <= '0;
            total_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    cva6_fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH),
        .dtype        (arb_entry_t),
        .FPGA_EN      (1'b0)
    ) i_entry_fifo (
        .clk_i      (clk_i),
        .rst_ni     (1'b1),
        .flush_i    (clear),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (push_entry),
        .push_i     (push),
        .data_o     (head_entry),
        .pop_i      (pop)
    );

    assign out_data_o  = head_entry.data;
    assign out_id_o    = head_entry.id;
    assign occupancy_o = cnt_q;
    assign usage_o     = total_q;

    // The local counters must track the storage's own bookkeeping exactly.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            assert (fifo_full == full);
            assert (fifo_empty == (total_q == '0));
            assert (fifo_usage == total_q[ADDR_W-1:0]);
            assert (total_q <= CNT_W'(DEPTH));
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                assert (cnt_q[i] <= CNT_W'(QUOTA));
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// tb/tb_fifo_rr_push_arbiter.sv - scoreboard bench for fifo_rr_push_arbiter
module tb_fifo_rr_push_arbiter;
    import fifo_rr_push_arbiter_pkg::*;

    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int QUOTA = 4;
    localparam int IDW   = 2;
    localparam int CW    = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][DW-1:0]  req_data;
    logic [NR-1:0]          req_ready;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic [IDW-1:0]         out_id;
    logic                   out_ready;
    logic [NR-1:0][CW-1:0]  occupancy;
    logic [CW-1:0]          usage;

    always #5 clk = ~clk;

    fifo_rr_push_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .QUOTA      (QUOTA)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_ready_i (out_ready),
        .occupancy_o (occupancy),
        .usage_o     (usage)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of source IDs plus per-requester counts and a next-start index.
    int     mcnt [NR];
    int     mtotal = 0;
    int     mptr   = 0;
    int     mq [$];
    entry_t sb_q [$];

    always @(negedge clk) begin : model
        int            win;
        int            idx;
        int            h;
        logic [NR-1:0] exp_ready;
        logic          exp_valid;
        entry_t        e;
        win = -1;
        if (rst_n && !flush && mtotal < DEPTH) begin
            for (int k = 0; k < NR; k++) begin
                idx = (mptr + k) % NR;
                if (win < 0 && req_valid[idx] && mcnt[idx] < QUOTA) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_valid = rst_n && !flush && (mtotal != 0);
        check("req_ready", req_ready, exp_ready);
        check("out_valid", out_valid, exp_valid);
        check("usage", usage, mtotal);
        for (int i = 0; i < NR; i++) check($sformatf("occupancy[%0d]", i), occupancy[i], mcnt[i]);
        if (!rst_n || flush) begin
            for (int i = 0; i < NR; i++) mcnt[i] = 0;
            mtotal = 0;
            mptr   = 0;
            mq.delete();
            sb_q.delete();
        end else begin
            if (exp_valid && out_ready) begin
                h = mq.pop_front();
                mcnt[h]--;
                mtotal--;
            end
            if (win >= 0) begin
                mq.push_back(win);
                e.id   = IDW'(win);
                e.data = req_data[win];
                sb_q.push_back(e);
                mcnt[win]++;
                mtotal++;
                mptr = (win + 1) % NR;
            end
        end
    end

    always @(negedge clk) begin : monitor
        entry_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_underflow: got out_id %0d with no expected entry", out_id);
            end else begin
                e = sb_q.pop_front();
                check("out_id", out_id, e.id);
                check("out_data", out_data, e.data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            for (int i = 0; i < NR; i++) req_data[i] = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    initial begin
        int thresh;
        logic [NR-1:0] exp_onehot;
        for (int i = 0; i < NR; i++) mcnt[i] = 0;
        rst_n = 1'b0; flush = 1'b0; req_valid = '0; out_ready = 1'b0; req_data = '0;
        step(3);
        rst_n = 1'b1;

        // Fairness: strict rotation with everyone valid and a draining consumer.
        req_valid = '1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_onehot = '0;
            exp_onehot[k % NR] = 1'b1;
            check("fair_grant", req_ready, exp_onehot);
            @(posedge clk); #1;
        end
        step(8);

        // Quota: lone requester stops at QUOTA, then resumes after a pop.
        do_flush();
        req_valid = 4'b0100; out_ready = 1'b0;
        step(4);
        @(negedge clk);
        check("quota_blocked", req_ready, 4'b0000);
        check("quota_occ2", occupancy[2], 4);
        check("quota_usage", usage, 4);
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        @(negedge clk);
        check("quota_regrant", req_ready, 4'b0100);
        @(posedge clk); #1;

        // Full: exactly DEPTH grants, pop at full frees a slot only next cycle.
        do_flush();
        req_valid = '1; out_ready = 1'b0;
        step(8);
        @(negedge clk);
        check("full_usage", usage, 8);
        check("full_no_grant", req_ready, 4'b0000);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_no_grant", req_ready, 4'b0000);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("after_pop_usage", usage, 7);
        check("after_pop_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        @(negedge clk);
        check("refill_usage", usage, 8);
        @(posedge clk); #1;

        // Same-ID push and pop every cycle keep the counts steady.
        do_flush();
        req_valid = 4'b0010; out_ready = 1'b0;
        step(2);
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("same_id_occ1", occupancy[1], 2);
            check("same_id_usage", usage, 2);
            @(posedge clk); #1;
        end

        // Flush mid-operation.
        do_flush();
        req_valid = '1; out_ready = 1'b0;
        step(5);
        flush = 1'b1;
        @(negedge clk);
        check("flush_no_grant", req_ready, 4'b0000);
        check("flush_no_valid", out_valid, 1'b0);
        check("flush_usage_before", usage, 5);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_usage_after", usage, 0);
        check("flush_occ_after", occupancy, '0);
        check("flush_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1;

        // Reset mid-operation.
        step(5);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_usage_before", usage, 6);
        check("rst_no_grant", req_ready, 4'b0000);
        check("rst_no_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_no_grant2", req_ready, 4'b0000);
        check("rst_no_valid2", out_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_usage_after", usage, 0);
        check("rst_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1;

        // Randomized traffic with varying consumer throughput.
        for (int blk = 0; blk < 6; blk++) begin
            thresh = blk % 4;
            repeat (500) begin
                req_valid = NR'($urandom);
                out_ready = ($urandom_range(0, 3) >= thresh);
                flush     = ($urandom_range(0, 49) == 0);
                rst_n     = ($urandom_range(0, 149) != 0);
                step(1);
            end
        end
        rst_n = 1'b1; flush = 1'b0; req_valid = '0; out_ready = 1'b1;
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
